// File: rtl/program_loader_pkg.sv
// Shared definitions for the program loader: loader states, stream framing
// constants and the instruction-field positions the core decodes.
package program_loader_pkg;

    localparam int DATA_W_DEFAULT = 64;
    localparam int BYTES_PER_WORD = DATA_W_DEFAULT / 8;
    localparam int HDR_BYTES      = 2;

    typedef enum logic [2:0] {
        LS_IDLE   = 3'd0,
        LS_HDR_LO = 3'd1,
        LS_HDR_HI = 3'd2,
        LS_DATA   = 3'd3,
        LS_WRITE  = 3'd4,
        LS_DONE   = 3'd5
    } loader_state_e;

    localparam logic [2:0] ST_IDLE   = LS_IDLE;
    localparam logic [2:0] ST_HDR_LO = LS_HDR_LO;
    localparam logic [2:0] ST_HDR_HI = LS_HDR_HI;
    localparam logic [2:0] ST_DATA   = LS_DATA;
    localparam logic [2:0] ST_WRITE  = LS_WRITE;
    localparam logic [2:0] ST_DONE   = LS_DONE;

    // Instruction field positions shared with the core's decoder.
    localparam int CTRL_LSB = 0;
    localparam int CTRL_MSB = 5;
    localparam int WADR_LSB = 6;
    localparam int WADR_MSB = 11;
    localparam int RA1_LSB  = 12;
    localparam int RA1_MSB  = 17;
    localparam int RA2_LSB  = 18;
    localparam int RA2_MSB  = 23;

    function automatic int lane_lsb(input int lane);
        return lane * 8;
    endfunction

endpackage

// File: rtl/program_loader_word_packer.sv
// Little-endian byte-lane assembler: each loaded byte lands in the next lane,
// full flags the last lane so the next load completes the word.
module program_loader_word_packer
    import program_loader_pkg::*;
#(
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              clear,
    input  logic [7:0]        byte_in,
    output logic [DATA_W-1:0] data,
    output logic              full
);

    localparam int BPW   = DATA_W / 8;
    localparam int IDX_W = (BPW > 1) ? $clog2(BPW) : 1;

    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [DATA_W-1:0] data_q, data_d;

    assign full = (idx_q == IDX_W'(BPW - 1));
    assign data = data_q;

    // Lanes are overwritten in place; the word is never cleared between writes.
    always_comb begin
        data_d = data_q;
        idx_d  = idx_q;
        if (clear) begin
            idx_d = '0;
        end else if (load) begin
            data_d[lane_lsb(int'(idx_q)) +: 8] = byte_in;
            idx_d = full ? '0 : idx_q + IDX_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q  <= '0;
            data_q <= '0;
        end else begin
            idx_q  <= idx_d;
            data_q <= data_d;
        end
    end

endmodule

// File: rtl/program_loader.sv
// Loads a length-prefixed byte stream into instruction RAM as packed words
// at consecutive addresses starting at BASE_ADR, then raises done.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int                ADDR_W   = 16,
    parameter int                DATA_W   = 64,
    parameter logic [ADDR_W-1:0] BASE_ADR = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [ADDR_W-1:0] mem_adr,
    output logic [DATA_W-1:0] mem_writeData,
    output logic              mem_writeEn,
    output logic              busy,
    output logic              done,
    output logic [2:0]        dbg_state
);

    logic [2:0]        state_q, state_d;
    logic [7:0]        len_lo_q, len_lo_d;
    logic [15:0]       remaining_q, remaining_d;
    logic [ADDR_W-1:0] mem_adr_q, mem_adr_d;
    logic [15:0]       len_full;
    logic              xfer;
    logic              pk_load;
    logic              pk_clear;
    logic              pk_full;

    // Handshake: a byte moves when in_valid & in_ready; in_ready depends on state only.
    assign in_ready = (state_q == ST_HDR_LO) || (state_q == ST_HDR_HI) ||
                      (state_q == ST_DATA);
    assign xfer     = in_valid && in_ready;
    assign len_full = {in_data, len_lo_q};

    assign mem_writeEn = (state_q == ST_WRITE);
    assign busy        = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign done        = (state_q == ST_DONE);
    assign mem_adr     = mem_adr_q;
    assign dbg_state   = state_q;

    always_comb begin
        state_d     = state_q;
        len_lo_d    = len_lo_q;
        remaining_d = remaining_q;
        mem_adr_d   = mem_adr_q;
        pk_load     = 1'b0;
        pk_clear    = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) state_d = ST_HDR_LO;
            end
            ST_HDR_LO: begin
                if (xfer) begin
                    len_lo_d = in_data;
                    state_d  = ST_HDR_HI;
                end
            end
            ST_HDR_HI: begin
                if (xfer) begin
                    if (len_full == 16'd0) begin
                        state_d = ST_DONE;
                    end else begin
                        remaining_d = len_full;
                        mem_adr_d   = BASE_ADR;
                        pk_clear    = 1'b1;
                        state_d     = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (xfer) begin
                    pk_load = 1'b1;
                    if (pk_full) state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                mem_adr_d   = mem_adr_q + ADDR_W'(1);
                remaining_d = remaining_q - 16'd1;
                state_d     = (remaining_q == 16'd1) ? ST_DONE : ST_DATA;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            len_lo_q    <= '0;
            remaining_q <= '0;
            mem_adr_q   <= BASE_ADR;
        end else begin
            state_q     <= state_d;
            len_lo_q    <= len_lo_d;
            remaining_q <= remaining_d;
            mem_adr_q   <= mem_adr_d;
        end
    end

    program_loader_word_packer #(
        .DATA_W (DATA_W)
    ) u_packer (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (pk_load),
        .clear   (pk_clear),
        .byte_in (in_data),
        .data    (mem_writeData),
        .full    (pk_full)
    );

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: two instances (BASE_ADR 0 and 0xFFFF) share clock,
// reset and data; sel picks which one the driver tasks talk to.
module tb_program_loader;
    import program_loader_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  start_v;
    logic [1:0]  valid_v;
    logic [7:0]  in_data;
    logic        sel;

    logic        rdy0, wen0, busy0, done0, rdy1, wen1, busy1, done1;
    logic [15:0] adr0, adr1;
    logic [63:0] wd0, wd1;
    logic [2:0]  dbg0, dbg1;

    logic        cur_ready, cur_wen, cur_busy, cur_done;
    logic [15:0] cur_adr;
    logic [63:0] cur_data;
    logic [2:0]  cur_dbg;

    int tests_run = 0;
    int tests_failed = 0;
    int stall_write, stall_other, cur_stall, max_stall, ready_viol;

    logic [63:0] exp_q[$];
    logic [15:0] exp_adr_q[$];
    logic [63:0] obs_q[$];
    logic [15:0] obs_adr_q[$];

    always #5 clk = ~clk;

    program_loader #(.ADDR_W(16), .DATA_W(64), .BASE_ADR(16'h0000)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .in_data(in_data),
        .in_valid(valid_v[0]), .in_ready(rdy0), .mem_adr(adr0), .mem_writeData(wd0),
        .mem_writeEn(wen0), .busy(busy0), .done(done0), .dbg_state(dbg0)
    );

    program_loader #(.ADDR_W(16), .DATA_W(64), .BASE_ADR(16'hFFFF)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .in_data(in_data),
        .in_valid(valid_v[1]), .in_ready(rdy1), .mem_adr(adr1), .mem_writeData(wd1),
        .mem_writeEn(wen1), .busy(busy1), .done(done1), .dbg_state(dbg1)
    );

    assign cur_ready = sel ? rdy1  : rdy0;
    assign cur_wen   = sel ? wen1  : wen0;
    assign cur_busy  = sel ? busy1 : busy0;
    assign cur_done  = sel ? done1 : done0;
    assign cur_adr   = sel ? adr1  : adr0;
    assign cur_data  = sel ? wd1   : wd0;
    assign cur_dbg   = sel ? dbg1  : dbg0;

    // Write monitor: every strobed cycle becomes one observed RAM write.
    always @(negedge clk) begin
        if (rst_n && cur_wen) begin
            obs_adr_q.push_back(cur_adr);
            obs_q.push_back(cur_data);
            if (cur_ready) ready_viol++;
        end
    end

    task automatic clear_books();
        exp_q.delete(); exp_adr_q.delete(); obs_q.delete(); obs_adr_q.delete();
        stall_write = 0; stall_other = 0; cur_stall = 0; max_stall = 0;
    endtask

    task automatic drive_valid(input logic v);
        valid_v = v ? (sel ? 2'b10 : 2'b01) : 2'b00;
    endtask

    task automatic pulse_start();
        start_v = sel ? 2'b10 : 2'b01;
        @(negedge clk);
        start_v = 2'b00;
    endtask

    // Presents one byte at a negedge and holds it until accepted.
    task automatic send_byte(input logic [7:0] b);
        int waited = 0;
        in_data = b;
        drive_valid(1'b1);
        cur_stall = 0;
        while (!cur_ready) begin
            if (cur_wen) stall_write++; else stall_other++;
            cur_stall++;
            if (cur_stall > max_stall) max_stall = cur_stall;
            @(negedge clk);
            waited++;
            if (waited > 50) begin
                tests_run++; tests_failed++;
                $display("FAIL send_byte: in_ready low for %0d cycles, required accept", waited);
                break;
            end
        end
        @(negedge clk);
        drive_valid(1'b0);
    endtask

    task automatic send_header(input int len);
        logic [15:0] l;
        l = 16'(len);
        send_byte(l[7:0]);
        send_byte(l[15:8]);
    endtask

    // gap_mode 0: back-to-back; 1: valid every other cycle except a byte
    // offered right after each word completes; 2: random gaps 0..2.
    task automatic send_payload(input int len, input int gap_mode,
                                input logic [15:0] base, input int mid_start);
        logic [63:0] w;
        logic [7:0]  b;
        int          gap;
        for (int i = 0; i < len; i++) begin
            w = '0;
            for (int k = 0; k < 8; k++) begin
                if (i * 8 + k == mid_start) pulse_start();
                b = 8'($urandom);
                w = w | (64'(b) << (8 * k));
                send_byte(b);
                case (gap_mode)
                    1:       gap = (k == 7) ? 0 : 1;
                    2:       gap = $urandom_range(2, 0);
                    default: gap = 0;
                endcase
                repeat (gap) @(negedge clk);
            end
            exp_adr_q.push_back(base + 16'(i));
            exp_q.push_back(w);
        end
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (!cur_done && n < 100) begin
            @(negedge clk);
            n++;
        end
        tests_run++;
        if (cur_done !== 1'b1) begin
            tests_failed++;
            $display("FAIL %s wait_done: done=%b after %0d cycles, required 1", name, cur_done, n);
        end
    endtask

    task automatic test_reset();
        sel = 1'b0;
        clear_books();
        pulse_start();
        send_header(1);
        send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if ({cur_ready, cur_wen, cur_busy, cur_done} !== 4'b0000) begin
            tests_failed++;
            $display("FAIL reset_flags: rdy/wen/busy/done=%b, required 0000",
                     {cur_ready, cur_wen, cur_busy, cur_done});
        end
        tests_run++;
        if (cur_adr !== 16'h0000 || cur_data !== 64'h0) begin
            tests_failed++;
            $display("FAIL reset_mem: adr=%h data=%h, required 0000/0", cur_adr, cur_data);
        end
        tests_run++;
        if (cur_dbg !== ST_IDLE) begin
            tests_failed++;
            $display("FAIL reset_state: state=%0d, required %0d", cur_dbg, ST_IDLE);
        end
        @(negedge clk);
        rst_n = 1'b1;
        in_data = 8'h55;
        drive_valid(1'b1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            tests_run++;
            if (cur_ready !== 1'b0 || cur_busy !== 1'b0) begin
                tests_failed++;
                $display("FAIL reset_idle: cycle %0d in_ready=%b busy=%b, required 0/0",
                         i, cur_ready, cur_busy);
            end
        end
        drive_valid(1'b0);
    endtask

    task automatic test_single_word();
        sel = 1'b0;
        clear_books();
        pulse_start();
        tests_run++;
        if (cur_busy !== 1'b1 || cur_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL single_start: busy=%b in_ready=%b, required 1/1", cur_busy, cur_ready);
        end
        send_header(1);
        for (int k = 1; k <= 8; k++) send_byte(8'(k));
        tests_run++;
        if (cur_wen !== 1'b1 || cur_adr !== 16'h0000 || cur_data !== 64'h0807060504030201) begin
            tests_failed++;
            $display("FAIL single_write: wen=%b adr=%h data=%h, required 1/0000/0807060504030201",
                     cur_wen, cur_adr, cur_data);
        end
        @(negedge clk);
        tests_run++;
        if (cur_done !== 1'b1 || cur_busy !== 1'b0 || cur_wen !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_done: done=%b busy=%b wen=%b, required 1/0/0",
                     cur_done, cur_busy, cur_wen);
        end
        repeat (3) @(negedge clk);
        tests_run++;
        if (obs_q.size() != 1) begin
            tests_failed++;
            $display("FAIL single_count: %0d writes, required 1", obs_q.size());
        end
    endtask

    task automatic check_writes(input string name);
        tests_run++;
        if (obs_q.size() != exp_q.size()) begin
            tests_failed++;
            $display("FAIL %s count: %0d writes, required %0d", name, obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            logic [63:0] od, ed;
            logic [15:0] oa, ea;
            od = obs_q.pop_front(); oa = obs_adr_q.pop_front();
            ed = exp_q.pop_front(); ea = exp_adr_q.pop_front();
            tests_run++;
            if (od !== ed || oa !== ea) begin
                tests_failed++;
                $display("FAIL %s word: adr=%h data=%h, required adr=%h data=%h", name, oa, od, ea, ed);
            end
        end
    endtask

    task automatic test_bubbles();
        sel = 1'b0;
        clear_books();
        pulse_start();
        send_header(2);
        send_payload(2, 1, 16'h0000, -1);
        wait_done("bubbles");
        repeat (3) @(negedge clk);
        check_writes("bubbles");
        tests_run++;
        if (stall_write != 1 || stall_other != 0 || max_stall != 1) begin
            tests_failed++;
            $display("FAIL bubbles_stall: in_write=%0d other=%0d max=%0d, required 1/0/1",
                     stall_write, stall_other, max_stall);
        end
    endtask

    task automatic test_zero_len();
        sel = 1'b0;
        clear_books();
        pulse_start();
        send_header(0);
        tests_run++;
        if (cur_done !== 1'b1 || cur_busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL zero_len_done: done=%b busy=%b, required 1/0", cur_done, cur_busy);
        end
        repeat (3) @(negedge clk);
        tests_run++;
        if (obs_q.size() != 0) begin
            tests_failed++;
            $display("FAIL zero_len_writes: %0d writes, required 0", obs_q.size());
        end
    endtask

    task automatic test_reset_partial();
        sel = 1'b0;
        clear_books();
        pulse_start();
        send_header(1);
        for (int k = 0; k < 5; k++) send_byte(8'hE0 + 8'(k));
        #2 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        pulse_start();
        send_header(1);
        send_payload(1, 2, 16'h0000, -1);
        wait_done("reset_partial");
        repeat (2) @(negedge clk);
        check_writes("reset_partial");
    endtask

    task automatic test_wrap_restart();
        sel = 1'b1;
        clear_books();
        pulse_start();
        send_header(2);
        send_payload(2, 2, 16'hFFFF, 3);
        tests_run++;
        if (cur_busy !== 1'b1 && cur_done !== 1'b1) begin
            tests_failed++;
            $display("FAIL wrap_busy: busy=%b done=%b, required busy or done", cur_busy, cur_done);
        end
        wait_done("wrap");
        repeat (2) @(negedge clk);
        check_writes("wrap");
        pulse_start();
        tests_run++;
        if (cur_done !== 1'b0 || cur_busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL wrap_restart: done=%b busy=%b, required 0/1", cur_done, cur_busy);
        end
        send_header(0);
        tests_run++;
        if (cur_done !== 1'b1) begin
            tests_failed++;
            $display("FAIL wrap_reload_done: done=%b, required 1", cur_done);
        end
    endtask

    task automatic test_random_loads();
        sel = 1'b0;
        for (int it = 0; it < 4; it++) begin
            int len;
            clear_books();
            len = $urandom_range(3, 1);
            pulse_start();
            send_header(len);
            send_payload(len, 2, 16'h0000, -1);
            wait_done("random");
            repeat (2) @(negedge clk);
            check_writes("random");
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start_v = 2'b00;
        valid_v = 2'b00;
        in_data = 8'h00;
        sel = 1'b0;
        ready_viol = 0;
        clear_books();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        test_reset();
        test_single_word();
        test_bubbles();
        test_zero_len();
        test_reset_partial();
        test_wrap_restart();
        test_random_loads();

        tests_run++;
        if (ready_viol != 0) begin
            tests_failed++;
            $display("FAIL ready_in_write: %0d write cycles with in_ready high, required 0", ready_viol);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
